// File: rtl/mau_mult_arbiter.sv
// Round-robin arbiter sharing one mantissa/exponent/sign multiplier between NUM_REQ
// requesters through a two-stage (operand, result) pipeline with a tagged response.
module mau_mult_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*18-1:0] req_a_mantissa,
  input  logic [NUM_REQ*18-1:0] req_b_mantissa,
  input  logic [NUM_REQ*5-1:0]  req_a_exponent,
  input  logic [NUM_REQ*5-1:0]  req_b_exponent,
  input  logic [NUM_REQ-1:0]    req_a_sign,
  input  logic [NUM_REQ-1:0]    req_b_sign,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [ID_W-1:0]       resp_id,
  output logic [17:0]           resp_mantissa,
  output logic [4:0]            resp_exponent,
  output logic                  resp_sign,
  output logic                  busy
);

  logic            s1_valid_q;
  logic [ID_W-1:0] s1_id_q;
  logic [17:0]     s1_am_q, s1_bm_q;
  logic [4:0]      s1_ae_q, s1_be_q;
  logic            s1_as_q, s1_bs_q;

  logic            s2_valid_q;
  logic [ID_W-1:0] s2_id_q;
  logic [17:0]     s2_m_q;
  logic [4:0]      s2_e_q;
  logic            s2_s_q;

  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] win_id, win_idx;
  logic            win_found, grant;
  logic            s2_free, s1_adv, s1_free;

  logic [17:0]     c_m;
  logic [5:0]      esum;
  logic [4:0]      c_e;
  logic            c_s;

  assign s2_free = !s2_valid_q | resp_ready;
  assign s1_adv  = s1_valid_q & s2_free;
  assign s1_free = !s1_valid_q | s1_adv;

  // First valid requester at or after rr_ptr, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    win_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      win_idx = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!win_found && req_valid[win_idx]) begin
        win_found = 1'b1;
        win_id    = win_idx;
      end
    end
  end

  assign grant    = win_found & s1_free;
  assign rr_ptr_d = (int'(win_id) == NUM_REQ - 1) ? '0 : win_id + 1'b1;

  always_comb begin
    req_ready = '0;
    if (grant && rst_n) req_ready[win_id] = 1'b1;
  end

  assign c_m  = 18'((36'(s1_am_q) * 36'(s1_bm_q)) >> 18);
  assign esum = 6'(s1_ae_q) + 6'(s1_be_q);
  assign c_s  = s1_as_q ^ s1_bs_q;

  // Exponent bias is 14 per operand pair; clamp to the 5-bit range.
  always_comb begin
    if (esum < 6'd14)      c_e = '0;
    else if (esum > 6'd45) c_e = 5'd31;
    else                   c_e = 5'(esum - 6'd14);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      s1_valid_q <= 1'b0;
      s1_id_q    <= '0;
      s1_am_q    <= '0;
      s1_bm_q    <= '0;
      s1_ae_q    <= '0;
      s1_be_q    <= '0;
      s1_as_q    <= 1'b0;
      s1_bs_q    <= 1'b0;
    end else if (grant) begin
      rr_ptr_q   <= rr_ptr_d;
      s1_valid_q <= 1'b1;
      s1_id_q    <= win_id;
      s1_am_q    <= req_a_mantissa[18*win_id +: 18];
      s1_bm_q    <= req_b_mantissa[18*win_id +: 18];
      s1_ae_q    <= req_a_exponent[5*win_id +: 5];
      s1_be_q    <= req_b_exponent[5*win_id +: 5];
      s1_as_q    <= req_a_sign[win_id];
      s1_bs_q    <= req_b_sign[win_id];
    end else if (s1_adv) begin
      s1_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_id_q    <= '0;
      s2_m_q     <= '0;
      s2_e_q     <= '0;
      s2_s_q     <= 1'b0;
    end else if (s1_adv) begin
      s2_valid_q <= 1'b1;
      s2_id_q    <= s1_id_q;
      s2_m_q     <= c_m;
      s2_e_q     <= c_e;
      s2_s_q     <= c_s;
    end else if (s2_valid_q && resp_ready) begin
      s2_valid_q <= 1'b0;
    end
  end

  assign resp_valid    = s2_valid_q;
  assign resp_id       = s2_id_q;
  assign resp_mantissa = s2_m_q;
  assign resp_exponent = s2_e_q;
  assign resp_sign     = s2_s_q;
  assign busy          = s1_valid_q | s2_valid_q;

endmodule

// File: tb/tb_mau_mult_arbiter.sv
// Bench for mau_mult_arbiter: directed vector table, round-robin/backpressure/reset
// sequences and a random run checked against a queue-based transaction model.
module tb_mau_mult_arbiter;
  localparam int N = 4;

  logic            clk, rst_n;
  logic [N-1:0]    req_valid, req_ready;
  logic [N*18-1:0] req_a_mantissa, req_b_mantissa;
  logic [N*5-1:0]  req_a_exponent, req_b_exponent;
  logic [N-1:0]    req_a_sign, req_b_sign;
  logic            resp_valid, resp_ready;
  logic [1:0]      resp_id;
  logic [17:0]     resp_mantissa;
  logic [4:0]      resp_exponent;
  logic            resp_sign, busy;

  mau_mult_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a_mantissa(req_a_mantissa), .req_b_mantissa(req_b_mantissa),
    .req_a_exponent(req_a_exponent), .req_b_exponent(req_b_exponent),
    .req_a_sign(req_a_sign), .req_b_sign(req_b_sign),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_mantissa(resp_mantissa), .resp_exponent(resp_exponent),
    .resp_sign(resp_sign), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [17:0] op_am [N];
  logic [17:0] op_bm [N];
  logic [4:0]  op_ae [N];
  logic [4:0]  op_be [N];
  logic        op_as [N];
  logic        op_bs [N];

  always_comb begin
    req_a_mantissa = '0; req_b_mantissa = '0;
    req_a_exponent = '0; req_b_exponent = '0;
    req_a_sign = '0; req_b_sign = '0;
    for (int i = 0; i < N; i++) begin
      req_a_mantissa[18*i +: 18] = op_am[i];
      req_b_mantissa[18*i +: 18] = op_bm[i];
      req_a_exponent[5*i +: 5]   = op_ae[i];
      req_b_exponent[5*i +: 5]   = op_be[i];
      req_a_sign[i] = op_as[i];
      req_b_sign[i] = op_bs[i];
    end
  end

  typedef struct { int id; int m; int e; int s; int t; } item_t;
  typedef struct {
    int id; logic [17:0] am, bm; logic [4:0] ae, be; logic sa, sb;
    logic [17:0] em; logic [4:0] ee; logic es;
  } vec_t;

  item_t q[$];
  int ptr, cyc, errors, checks;
  int wait_cnt [N];
  logic [N-1:0] last_grant;
  logic obs_rv; int obs_id, obs_m, obs_e, obs_s;

  task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic rand_op(input int i);
    op_am[i] = 18'($urandom); op_bm[i] = 18'($urandom);
    op_ae[i] = 5'($urandom);  op_be[i] = 5'($urandom);
    op_as[i] = 1'($urandom);  op_bs[i] = 1'($urandom);
  endtask

  function automatic item_t ref_mul(input int id, input logic [17:0] am, input logic [17:0] bm,
                                    input logic [4:0] ae, input logic [4:0] be,
                                    input logic sa, input logic sb);
    item_t r;
    int sum;
    r.id = id;
    r.m = int'((longint'(am) * longint'(bm)) / 262144);
    sum = int'(ae) + int'(be);
    r.e = (sum < 14) ? 0 : ((sum - 14 > 31) ? 31 : sum - 14);
    r.s = int'(sa != sb);
    r.t = 0;
    return r;
  endfunction

  // One clock: called just after a rising edge, returns just after the next one.
  task automatic step(input logic [N-1:0] v, input logic rr);
    bit found, can, exp_rv, drain;
    int w;
    logic [N-1:0] exp_ready;
    item_t it;
    req_valid = v; resp_ready = rr;
    @(negedge clk);
    exp_rv = (q.size() > 0) && ((cyc - q[0].t) >= 1);
    chk(resp_valid == exp_rv, "resp_valid", resp_valid, exp_rv);
    chk(busy == (q.size() > 0), "busy", busy, q.size() > 0);
    obs_rv = resp_valid; obs_id = resp_id; obs_m = resp_mantissa;
    obs_e = resp_exponent; obs_s = resp_sign;
    if (exp_rv && resp_valid) begin
      chk(resp_id == q[0].id, "resp_id", resp_id, q[0].id);
      chk(resp_mantissa == q[0].m, "resp_mantissa", resp_mantissa, q[0].m);
      chk(resp_exponent == q[0].e, "resp_exponent", resp_exponent, q[0].e);
      chk(resp_sign == q[0].s, "resp_sign", resp_sign, q[0].s);
    end
    drain = exp_rv && rr;
    found = 1'b0; w = 0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (ptr + k) % N;
      if (!found && v[j]) begin found = 1'b1; w = j; end
    end
    can = (q.size() - int'(drain)) < 2;
    exp_ready = '0;
    if (found && can) exp_ready[w] = 1'b1;
    chk(req_ready == exp_ready, "req_ready", req_ready, exp_ready);
    last_grant = exp_ready;
    if (drain) void'(q.pop_front());
    for (int j = 0; j < N; j++) begin
      if (!v[j]) wait_cnt[j] = 0;
      else if (found && can) begin
        if (j == w) wait_cnt[j] = 0;
        else begin
          wait_cnt[j]++;
          chk(wait_cnt[j] <= N - 1, "fairness_wait", wait_cnt[j], N - 1);
        end
      end
    end
    if (found && can) begin
      it = ref_mul(w, op_am[w], op_bm[w], op_ae[w], op_be[w], op_as[w], op_bs[w]);
      it.t = cyc + 1;
      q.push_back(it);
      ptr = (w + 1) % N;
    end
    @(posedge clk); #1;
    cyc++;
    if (found && can) rand_op(w);
  endtask

  vec_t vecs[7];
  logic [N-1:0] pending;
  int acc;

  initial begin
    errors = 0; checks = 0; cyc = 0; ptr = 0; last_grant = '0;
    for (int i = 0; i < N; i++) begin rand_op(i); wait_cnt[i] = 0; end
    vecs[0] = '{2, 18'h20000, 18'h20000, 5'd15, 5'd15, 1'b1, 1'b0, 18'h10000, 5'd16, 1'b1};
    vecs[1] = '{1, 18'h3FFFF, 18'h3FFFF, 5'd3,  5'd4,  1'b0, 1'b0, 18'h3FFFE, 5'd0,  1'b0};
    vecs[2] = '{1, 18'h20000, 18'h3FFFF, 5'd31, 5'd31, 1'b1, 1'b1, 18'h1FFFF, 5'd31, 1'b0};
    vecs[3] = '{0, 18'h00000, 18'h12345, 5'd14, 5'd0,  1'b0, 1'b1, 18'h00000, 5'd0,  1'b1};
    vecs[4] = '{3, 18'h10000, 18'h00004, 5'd31, 5'd14, 1'b1, 1'b0, 18'h00001, 5'd31, 1'b1};
    vecs[5] = '{3, 18'h30000, 18'h30000, 5'd31, 5'd15, 1'b0, 1'b0, 18'h24000, 5'd31, 1'b0};
    vecs[6] = '{0, 18'h2AAAA, 18'h00003, 5'd8,  5'd7,  1'b1, 1'b1, 18'h00001, 5'd1,  1'b0};

    rst_n = 1'b0; req_valid = '1; resp_ready = 1'b1;
    #12;
    chk(req_ready == 0, "reset_req_ready", req_ready, 0);
    chk(resp_valid == 0, "reset_resp_valid", resp_valid, 0);
    chk(busy == 0, "reset_busy", busy, 0);
    chk(resp_id == 0 && resp_mantissa == 0 && resp_exponent == 0 && resp_sign == 0,
        "reset_resp_data", resp_mantissa, 0);
    req_valid = '0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Round robin with all requesters valid and no backpressure.
    for (int k = 0; k < 10; k++) begin
      step('1, 1'b1);
      chk(last_grant == N'(1 << (k % N)), "rr_grant", last_grant, 1 << (k % N));
      if (k >= 2) chk(obs_rv && obs_id == (k - 2) % N, "rr_resp_id", obs_id, (k - 2) % N);
    end
    repeat (3) step('0, 1'b1);

    // Backpressure: only S1 and S2 can be filled.
    acc = 0;
    for (int k = 0; k < 4; k++) begin
      step('1, 1'b0);
      if (last_grant != 0) acc++;
    end
    chk(acc == 2, "bp_accepts", acc, 2);
    repeat (4) step('0, 1'b1);

    // Directed arithmetic vectors.
    foreach (vecs[n]) begin
      op_am[vecs[n].id] = vecs[n].am; op_bm[vecs[n].id] = vecs[n].bm;
      op_ae[vecs[n].id] = vecs[n].ae; op_be[vecs[n].id] = vecs[n].be;
      op_as[vecs[n].id] = vecs[n].sa; op_bs[vecs[n].id] = vecs[n].sb;
      step(N'(1 << vecs[n].id), 1'b1);
      step('0, 1'b1);
      chk(obs_rv == 1'b0, "vec_latency", obs_rv, 0);
      step('0, 1'b1);
      chk(obs_rv == 1'b1, "vec_valid", obs_rv, 1);
      chk(obs_id == vecs[n].id, "vec_id", obs_id, vecs[n].id);
      chk(obs_m == int'(vecs[n].em), "vec_mantissa", obs_m, vecs[n].em);
      chk(obs_e == int'(vecs[n].ee), "vec_exponent", obs_e, vecs[n].ee);
      chk(obs_s == int'(vecs[n].es), "vec_sign", obs_s, vecs[n].es);
    end

    // Reset mid-cycle with both stages full.
    step('1, 1'b0);
    step('1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk(resp_valid == 0, "midrst_resp_valid", resp_valid, 0);
    chk(busy == 0, "midrst_busy", busy, 0);
    chk(req_ready == 0, "midrst_req_ready", req_ready, 0);
    q.delete(); ptr = 0;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    @(negedge clk); req_valid = '0; rst_n = 1'b1;
    @(posedge clk); #1;
    step('1, 1'b1);
    chk(last_grant == 1, "post_reset_grant", last_grant, 1);
    repeat (3) step('0, 1'b1);

    // Random stress with sticky valids.
    pending = '0;
    for (int k = 0; k < 10000; k++) begin
      logic [N-1:0] v;
      v = pending | (N'($urandom) & N'($urandom));
      step(v, ($urandom_range(0, 3) != 0));
      pending = v & ~last_grant;
    end
    repeat (4) step('0, 1'b1);
    chk(q.size() == 0, "final_drain", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mau_mult_arbiter.md
Name: mau_mult_arbiter

Overview:
- Shares one MAU_Multiplier (18-bit mantissa, 5-bit biased exponent, sign) between NUM_REQ requesters, e.g. the MAU row/column engines.
- Round-robin arbitration over valid/ready request ports.
- Two-stage registered pipeline: operand register, then result register.
- One tagged response stream with backpressure; full throughput of one product per clock.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(NUM_REQ), derived localparam, not overridable; width of resp_id.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester operand pair valid
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
- req_a_mantissa  in  NUM_REQ*18  packed, requester i at [18*i+:18]
- req_b_mantissa  in  NUM_REQ*18  packed, same layout
- req_a_exponent  in  NUM_REQ*5  packed, requester i at [5*i+:5]
- req_b_exponent  in  NUM_REQ*5  packed, same layout
- req_a_sign  in  NUM_REQ  bit i = requester i
- req_b_sign  in  NUM_REQ  bit i = requester i
- resp_valid  out  1  result valid
- resp_ready  in  1  consumer accepts result
- resp_id  out  ID_W  index of the requester that issued this result
- resp_mantissa  out  18  product mantissa
- resp_exponent  out  5  product exponent
- resp_sign  out  1  product sign
- busy  out  1  s1_valid | s2_valid

Behaviour:
- Reset: one clock; rst_n asynchronous, active low. Asserting rst_n clears s1_valid, s2_valid and rr_ptr (to 0). All registered outputs go to 0: resp_valid=0, resp_id=0, resp_mantissa/exponent/sign=0, busy=0. req_ready=0 while rst_n is low.
- Reset mid-operation: in-flight S1/S2 contents are dropped without a response. Operation resumes on the first clock edge after deassertion.
- Pipeline:
  - S1 holds {id, a/b mantissa, exponent, sign}.
  - The multiplier is combinational on S1.
  - S2 holds {id, c_mantissa, c_exponent, c_sign}, driving resp_* directly.
- Flow control:
  - s2_free = !s2_valid | resp_ready.
  - s1_adv = s1_valid & s2_free.
  - s1_free = !s1_valid | s1_adv.
- Arbitration:
  - Combinational scan from rr_ptr upward, wrapping mod NUM_REQ. The first i with req_valid[i]=1 is the winner.
  - req_ready[winner] = s1_free; all other req_ready bits = 0.
  - req_ready may depend on req_valid. Requesters must not make req_valid depend on req_ready.
- Handshake: req_valid[i] & req_ready[i] at an edge loads S1 with requester i's operands and id=i, and sets rr_ptr=(i+1) mod NUM_REQ. With no grant, rr_ptr holds.
- S1 update: loaded by a grant; otherwise, if s1_adv, s1_valid clears.
- S2 update: if s1_adv, S2 loads the multiplier result and sets s2_valid. Otherwise, if resp_valid & resp_ready, s2_valid clears. Otherwise S2 holds and resp_* are stable.
- Latency: a request accepted at edge t produces resp_valid high after edge t+1, i.e. the response is presented at edge t+2 at the earliest.
- Throughput: 1 per cycle with resp_ready held high. Back-to-back grants to different requesters are allowed in consecutive cycles.
- Backpressure: with resp_ready=0 and S2 full, S1 holds. A further request may fill S1 only if S1 is empty; then req_ready is 0 for everyone. Nothing is lost or duplicated.
- Simultaneous events in one cycle are legal:
  - S2 drains, S1 moves to S2, and a new grant loads S1.
  - Drain and refill of S2 in the same cycle.
- Arithmetic, as computed by MAU_Multiplier:
  - mantissa = (a_m*b_m)[35:18].
  - sign = a_s ^ b_s.
  - exponent = a_e+b_e-14, forced to 0 if a_e+b_e<14, forced to 31 if a_e+b_e-14>31.
- Ordering: responses leave in grant order. Fairness: a continuously-valid requester waits at most NUM_REQ-1 grants.

Test Plan:
- Reset/idle: rst_n pulsed low mid-cycle with S1 and S2 full -> immediately resp_valid=0, busy=0, req_ready=0; after release, first grant goes to requester 0 when all valid.
- Single multiply: requester 2 sends a_m=b_m=18'h20000, a_e=b_e=15, a_s=1, b_s=0 -> two edges later resp_valid=1, id=2, mantissa=18'h10000, exponent=16, sign=1.
- Exponent saturation: requester 1 sends a_e=3, b_e=4 -> exponent 0; then a_e=b_e=31 -> exponent 31.
- Round robin: all 4 req_valid held high with resp_ready=1 -> grants 0,1,2,3,0,... one per cycle; resp_id follows the same sequence.
- Backpressure: 4 requests issued with resp_ready=0 -> exactly 2 accepted (S2, S1) then req_ready=0. Release resp_ready -> responses drain in grant order with no loss or duplication. Compare each result against a reference model.
- Random stress: random req_valid and resp_ready over 10k cycles -> scoreboard matches every product and id; no requester starves beyond NUM_REQ-1 grants.
